// File: rtl/char_buf_sram_pkg.sv
// Shared types and helpers for the character-buffer dual-port SRAM.
package char_buf_sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    localparam int CB_DATA_W = 32;
    localparam int CB_BYTE_W = 8;
    localparam int BE_W      = CB_DATA_W / CB_BYTE_W;

    // Widest data word the merge helper handles; DATA_W must not exceed it.
    localparam int MAX_W = 256;

    // Byte-lane merge on an expanded bit mask: mask bits set take new_w.
    function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_w,
                                                    input logic [MAX_W-1:0] new_w,
                                                    input logic [MAX_W-1:0] mask);
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/char_buf_dual_port_sram_if.sv
// Avalon-MM slave port bundle for one side of the character-buffer SRAM.
interface char_buf_dual_port_sram_if
    import char_buf_sram_pkg::*;
#(
    parameter int DATA_W = CB_DATA_W,
    parameter int BYTE_W = CB_BYTE_W,
    parameter int ADDR_W = 11
) ();
    localparam int LANES = DATA_W / BYTE_W;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [LANES-1:0]  byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/char_buf_sram_rdpipe.sv
// Read-return pipeline: LATENCY stages of data/valid; data holds between valids.
module char_buf_sram_rdpipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);
    logic [LATENCY-1:0]             vld_q, vld_d;
    logic [LATENCY-1:0][DATA_W-1:0] data_q, data_d;

    // Shift valids every cycle; a stage only loads data when its input is valid.
    always_comb begin
        vld_d     = '0;
        data_d    = data_q;
        vld_d[0]  = in_vld;
        if (in_vld) data_d[0] = in_data;
        for (int s = 1; s < LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
            if (vld_q[s-1]) data_d[s] = data_q[s-1];
        end
    end

    // Pipeline registers, flushed on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q[LATENCY-1];
    assign out_data = data_q[LATENCY-1];
endmodule

// File: rtl/char_buf_dual_port_sram.sv
// True dual-port character-buffer SRAM with byte enables, s1-priority write
// collisions and a hardware clear engine that borrows port 2.
// Optional build macro CHAR_BUF_SRAM_FWD_EN: cross-port (and engine) write data
// is forwarded lane-wise to a same-cycle read of that address on the other port.
module char_buf_dual_port_sram
    import char_buf_sram_pkg::*;
#(
    parameter int                DATA_W       = CB_DATA_W,
    parameter int                BYTE_W       = CB_BYTE_W,
    parameter int                ADDR_W       = 11,
    parameter int                DEPTH        = 2048,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] FILL_VALUE   = DATA_W'(32'h0000_0020)
) (
    input  logic                       clk,
    input  logic                       reset,
    char_buf_dual_port_sram_if.slave   s1,
    char_buf_dual_port_sram_if.slave   s2,
    input  logic                       clear_start,
    output logic                       clear_busy,
    output logic                       clear_done
);
    localparam int                LANES   = DATA_W / BYTE_W;
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    clear_state_e      state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] mask1, mask2;
    logic              in1, in2, rd1_acc, rd2_acc, p1_we, p2_we;
    logic [ADDR_W-1:0] p2_addr;
    logic [DATA_W-1:0] p2_data, p2_mask, p2_new, p1_base, p1_new;
    logic [DATA_W-1:0] rd1_old, rd2_old, rd1_data, rd2_data;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o,
                                                input logic [DATA_W-1:0] n,
                                                input logic [DATA_W-1:0] m);
        return DATA_W'(lane_merge(MAX_W'(o), MAX_W'(n), MAX_W'(m)));
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_mask
        assign mask1[l*BYTE_W +: BYTE_W] = {BYTE_W{s1.byteenable[l]}};
        assign mask2[l*BYTE_W +: BYTE_W] = {BYTE_W{s2.byteenable[l]}};
    end

    // Request decode; while clearing, the engine replaces the s2 host on port 2.
    always_comb begin
        in1     = {1'b0, s1.address} < DEPTH_A;
        in2     = {1'b0, s2.address} < DEPTH_A;
        rd1_acc = s1.chipselect & s1.read;
        p1_we   = s1.chipselect & s1.write & in1;
        rd2_acc = s2.chipselect & s2.read & ~clear_busy;
        p2_we   = s2.chipselect & s2.write & in2 & ~clear_busy;
        p2_addr = s2.address;
        p2_data = s2.writedata;
        p2_mask = mask2;
        if (clear_busy) begin
            p2_we   = ~reset;
            p2_addr = clr_addr_q;
            p2_data = FILL_VALUE;
            p2_mask = '1;
        end
    end

    // Pre-write words; s1 merges on top of any same-address port-2 write so it wins per lane.
    always_comb begin
        rd1_old = in1 ? mem[s1.address[IDX_W-1:0]] : '0;
        rd2_old = in2 ? mem[s2.address[IDX_W-1:0]] : '0;
        p2_new  = merge(mem[p2_addr[IDX_W-1:0]], p2_data, p2_mask);
        p1_base = (p2_we && p2_addr == s1.address) ? p2_new : mem[s1.address[IDX_W-1:0]];
        p1_new  = merge(p1_base, s1.writedata, mask1);
    end

    // Read data selection for the return pipelines.
    always_comb begin
        rd1_data = rd1_old;
        rd2_data = rd2_old;
`ifdef CHAR_BUF_SRAM_FWD_EN
        if (p2_we && p2_addr == s1.address) rd1_data = merge(rd1_old, p2_data, p2_mask);
        if (p1_we && s1.address == s2.address) rd2_data = merge(rd2_old, s1.writedata, mask1);
`endif
    end

    // Storage writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (p2_we) mem[p2_addr[IDX_W-1:0]] <= p2_new;
        if (p1_we) mem[s1.address[IDX_W-1:0]] <= p1_new;
    end

    // Clear FSM next state: walk 0..DEPTH-1 once, pulse done after the last word.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_A) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear FSM registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            done_q     <= done_d;
        end
    end

    assign clear_busy     = (state_q == CLEAR);
    assign clear_done     = done_q;
    assign s2.waitrequest = clear_busy;
    assign s1.waitrequest = 1'b0;

    char_buf_sram_rdpipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd1 (
        .clk(clk), .reset(reset), .in_vld(rd1_acc), .in_data(rd1_data),
        .out_vld(s1.readdatavalid), .out_data(s1.readdata)
    );

    char_buf_sram_rdpipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd2 (
        .clk(clk), .reset(reset), .in_vld(rd2_acc), .in_data(rd2_data),
        .out_vld(s2.readdatavalid), .out_data(s2.readdata)
    );
endmodule

// File: tb/tb_char_buf_dual_port_sram.sv
// Scoreboard bench: two DUTs (read latency 1 and 2) share one stimulus stream.
module tb_char_buf_dual_port_sram;
    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int AW    = 12;
    localparam int DEPTH = 2048;
    localparam logic [31:0] FILL = 32'h0000_0020;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear_start = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    always #5 clk = ~clk;

    char_buf_dual_port_sram_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) a1 ();
    char_buf_dual_port_sram_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) a2 ();
    char_buf_dual_port_sram_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) b1 ();
    char_buf_dual_port_sram_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) b2 ();

    assign b1.address = a1.address;  assign b1.chipselect = a1.chipselect;
    assign b1.read = a1.read;        assign b1.write = a1.write;
    assign b1.byteenable = a1.byteenable; assign b1.writedata = a1.writedata;
    assign b2.address = a2.address;  assign b2.chipselect = a2.chipselect;
    assign b2.read = a2.read;        assign b2.write = a2.write;
    assign b2.byteenable = a2.byteenable; assign b2.writedata = a2.writedata;

    char_buf_dual_port_sram #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW), .DEPTH(DEPTH),
                              .READ_LATENCY(1), .FILL_VALUE(FILL)) dut_a (
        .clk(clk), .reset(reset), .s1(a1), .s2(a2),
        .clear_start(clear_start), .clear_busy(busy_a), .clear_done(done_a));

    char_buf_dual_port_sram #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW), .DEPTH(DEPTH),
                              .READ_LATENCY(2), .FILL_VALUE(FILL)) dut_b (
        .clk(clk), .reset(reset), .s1(b1), .s2(b2),
        .clear_start(clear_start), .clear_busy(busy_b), .clear_done(done_b));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    typedef struct { int id; int due; logic [31:0] d; } exp_t;
    exp_t        sbq[$];
    logic [31:0] mdl [DEPTH];
    bit          m_clr = 1'b0;
    int          m_caddr = 0;
    int          cyc = 0;
    int          busy_cyc_a = 0, busy_cyc_b = 0, wait_cyc_a = 0, done_n_a = 0, done_n_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] be2m(input logic [3:0] be);
        logic [31:0] m;
        for (int l = 0; l < 4; l++) m[l*8 +: 8] = be[l] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic set1(input bit r, input bit w, input int ad, input logic [3:0] be, input logic [31:0] d);
        a1.chipselect = r | w; a1.read = r; a1.write = w;
        a1.address = AW'(ad); a1.byteenable = be; a1.writedata = d;
    endtask

    task automatic set2(input bit r, input bit w, input int ad, input logic [3:0] be, input logic [31:0] d);
        a2.chipselect = r | w; a2.read = r; a2.write = w;
        a2.address = AW'(ad); a2.byteenable = be; a2.writedata = d;
    endtask

    task automatic idle();
        set1(0, 0, 0, 4'h0, 32'h0);
        set2(0, 0, 0, 4'h0, 32'h0);
    endtask

    // One clock: predict read results from the pre-write model, then apply writes.
    task automatic tick();
        int e1, e2;
        bit in1, in2, rd1, rd2, w1, w2;
        logic [31:0] m1, m2, d2, o1, o2, r1, r2;
        e1  = int'(a1.address);
        in1 = e1 < DEPTH;
        rd1 = a1.chipselect && a1.read && !reset;
        w1  = a1.chipselect && a1.write && in1 && !reset;
        m1  = be2m(a1.byteenable);
        if (m_clr) begin
            e2 = m_caddr; in2 = 1'b1; rd2 = 1'b0; w2 = !reset; m2 = '1; d2 = FILL;
        end else begin
            e2  = int'(a2.address);
            in2 = e2 < DEPTH;
            rd2 = a2.chipselect && a2.read && !reset;
            w2  = a2.chipselect && a2.write && in2 && !reset;
            m2  = be2m(a2.byteenable);
            d2  = a2.writedata;
        end
        o1 = in1 ? mdl[e1 % DEPTH] : 32'h0;
        o2 = in2 ? mdl[e2 % DEPTH] : 32'h0;
        r1 = o1;
        r2 = o2;
`ifdef CHAR_BUF_SRAM_FWD_EN
        if (w2 && e2 == e1) r1 = (o1 & ~m2) | (d2 & m2);
        if (w1 && e1 == e2) r2 = (o2 & ~m1) | (a1.writedata & m1);
`endif
        if (rd1) begin sbq.push_back('{0, cyc + 1, r1}); sbq.push_back('{2, cyc + 2, r1}); end
        if (rd2) begin sbq.push_back('{1, cyc + 1, r2}); sbq.push_back('{3, cyc + 2, r2}); end
        @(posedge clk);
        if (w2) mdl[e2] = (mdl[e2] & ~m2) | (d2 & m2);
        if (w1) mdl[e1] = (mdl[e1] & ~m1) | (a1.writedata & m1);
        if (reset) m_clr = 1'b0;
        else if (m_clr) begin
            if (m_caddr == DEPTH - 1) m_clr = 1'b0;
            m_caddr++;
        end else if (clear_start) begin
            m_clr = 1'b1;
            m_caddr = 0;
        end
        #1;
    endtask

    // Output monitor: pop the scoreboard on readdatavalid, flag late/missing returns.
    always @(negedge clk) begin
        if (!reset) begin
            for (int id = 0; id < 4; id++) begin
                logic v;
                logic [31:0] d;
                string tg;
                int k;
                case (id)
                    0: begin v = a1.readdatavalid; d = a1.readdata; tg = "a_s1"; end
                    1: begin v = a2.readdatavalid; d = a2.readdata; tg = "a_s2"; end
                    2: begin v = b1.readdatavalid; d = b1.readdata; tg = "b_s1"; end
                    default: begin v = b2.readdatavalid; d = b2.readdata; tg = "b_s2"; end
                endcase
                k = -1;
                for (int j = 0; j < sbq.size(); j++) if (sbq[j].id == id) begin k = j; break; end
                if (v) begin
                    if (k < 0) chk({tg, "_spurious_rdv"}, 32'd1, 32'd0);
                    else begin
                        chk({tg, "_latency"}, 32'(cyc), 32'(sbq[k].due));
                        chk({tg, "_data"}, d, sbq[k].d);
                        sbq.delete(k);
                    end
                end else if (k >= 0 && sbq[k].due <= cyc) begin
                    chk({tg, "_missing_rdv"}, 32'd0, 32'd1);
                    sbq.delete(k);
                end
            end
            if (busy_a) busy_cyc_a++;
            if (busy_b) busy_cyc_b++;
            if (a2.waitrequest) wait_cyc_a++;
            if (done_a) begin done_n_a++; chk("a_done_while_busy", 32'(busy_a), 32'd0); end
            if (done_b) begin done_n_b++; chk("b_done_while_busy", 32'(busy_b), 32'd0); end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (3) tick();
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_wait_a", 32'(a2.waitrequest), 32'd0);
        chk("rst_rdv_a1", 32'(a1.readdatavalid), 32'd0);
        chk("rst_rd_a1", a1.readdata, 32'd0);
        chk("rst_rdv_b2", 32'(b2.readdatavalid), 32'd0);
        chk("rst_rd_b2", b2.readdata, 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b0;
        tick();

        // Basic write then cross-port read.
        set1(0, 1, 5, 4'hF, 32'hDEADBEEF); tick();
        idle(); set2(1, 0, 5, 4'h0, 0); tick();
        // Partial byte-enable write.
        idle(); set1(0, 1, 7, 4'hF, 32'h11223344); tick();
        set1(0, 1, 7, 4'b0101, 32'hAABBCCDD); tick();
        set1(1, 0, 7, 4'h0, 0); tick();
        // Same-address write collision: s1 wins.
        set1(0, 1, 9, 4'hF, 32'h1); set2(0, 1, 9, 4'hF, 32'h2); tick();
        idle(); set1(1, 0, 9, 4'h0, 0); tick();
        // Partial collision: s2 lanes outside s1's byteenable survive.
        set1(0, 1, 11, 4'b0011, 32'h0000_AAAA); set2(0, 1, 11, 4'hF, 32'h5555_5555); tick();
        idle(); set2(1, 0, 11, 4'h0, 0); tick();
        // Cross-port read during write (forwarding depends on build).
        idle(); set1(0, 1, 3, 4'hF, 32'h0); tick();
        set1(0, 1, 3, 4'hF, 32'h5); set2(1, 0, 3, 4'h0, 0); tick();
        // Same-port read-during-write returns old data.
        idle(); set1(1, 1, 5, 4'hF, 32'hCAFE0005); tick();
        // Out-of-range writes are dropped; reads return zero.
        idle(); set1(0, 1, 952, 4'hF, 32'h0952_0952); tick();
        set1(0, 1, 3000, 4'hF, 32'hFFFF_FFFF); set2(0, 1, 4000, 4'hF, 32'hEEEE_EEEE); tick();
        set1(1, 0, 952, 4'h0, 0); set2(1, 0, 3000, 4'h0, 0); tick();
        idle(); repeat (4) tick();

        // Full clear with a restart attempt, s1 traffic and a blocked s2 read.
        busy_cyc_a = 0; busy_cyc_b = 0; wait_cyc_a = 0; done_n_a = 0; done_n_b = 0;
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            idle();
            clear_start = (i == 1000);
            if (m_clr && m_caddr == 10) set1(0, 1, 10, 4'hF, 32'h1234_5678);
            if (m_clr && m_caddr == 5) set1(1, 0, 5, 4'h0, 0);
            if (i == 500) set2(1, 0, 20, 4'h0, 0);
            tick();
        end
        clear_start = 1'b0;
        chk("clr_busy_cycles_a", 32'(busy_cyc_a), 32'(DEPTH));
        chk("clr_busy_cycles_b", 32'(busy_cyc_b), 32'(DEPTH));
        chk("clr_wait_cycles_a", 32'(wait_cyc_a), 32'(DEPTH));
        chk("clr_done_pulses_a", 32'(done_n_a), 32'd1);
        chk("clr_done_pulses_b", 32'(done_n_b), 32'd1);
        idle(); set1(1, 0, 0, 4'h0, 0); set2(1, 0, 2047, 4'h0, 0); tick();
        set1(1, 0, 10, 4'h0, 0); set2(1, 0, 9, 4'h0, 0); tick();
        idle(); repeat (3) tick();

        // Random two-port traffic over a small window plus out-of-range hits.
        for (int i = 0; i < 300; i++) begin
            set1($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) == 0) ? 3000 : $urandom_range(0, 15),
                 4'($urandom_range(0, 15)), $urandom);
            set2($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) == 0) ? 4000 : $urandom_range(0, 15),
                 4'($urandom_range(0, 15)), $urandom);
            tick();
        end
        idle(); repeat (4) tick();

        // Reset in the middle of a clear.
        set1(0, 1, 500, 4'hF, 32'hCAFE_F00D); tick();
        set1(0, 1, 50, 4'hF, 32'h5050_5050); tick();
        idle(); tick();
        done_n_a = 0; done_n_b = 0;
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        for (int i = 0; i < 200 && m_caddr < 100; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_busy_a", 32'(busy_a), 32'd0);
        chk("rst_mid_busy_b", 32'(busy_b), 32'd0);
        chk("rst_mid_wait_a", 32'(a2.waitrequest), 32'd0);
        repeat (3) tick();
        chk("rst_mid_no_done_a", 32'(done_n_a), 32'd0);
        chk("rst_mid_no_done_b", 32'(done_n_b), 32'd0);
        set1(1, 0, 50, 4'h0, 0); set2(1, 0, 500, 4'h0, 0); tick();
        set1(1, 0, 99, 4'h0, 0); set2(1, 0, 100, 4'h0, 0); tick();
        idle(); repeat (5) tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/char_buf_dual_port_sram.md
Name: char_buf_dual_port_sram

Overview:
Parametrised true-dual-port on-chip SRAM, the next generation of the character-buffer memory.
- Two Avalon-MM slaves: s1 for the CPU and s2 for the pixel/character pipeline.
- Adds selectable read latency with readdatavalid, byte-enabled writes of configurable width, a deterministic cross-port collision policy, and a hardware clear engine that fills the buffer (screen clear) without CPU traffic.
- Sits between the system interconnect and the character-buffer DMA/renderer.

Parameters:
DATA_W, 32, data width per port in bits; must be a multiple of BYTE_W
BYTE_W, 8, bits per byte-enable lane
ADDR_W, 11, word address width
DEPTH, 2048, number of words; must be <= 2**ADDR_W
READ_LATENCY, 1, read latency in cycles, 1 or 2; 2 adds an output register
FILL_VALUE, 32'h0000_0020, word written by the clear engine (ASCII space)

Ports:
clk  in  1  single clock for both ports and all logic
reset  in  1  synchronous, active-high reset
s1_address  in  ADDR_W  port 1 word address
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read strobe
s1_write  in  1  port 1 write strobe
s1_byteenable  in  DATA_W/BYTE_W  port 1 byte lanes
s1_writedata  in  DATA_W  port 1 write data
s1_readdata  out  DATA_W  port 1 read data
s1_readdatavalid  out  1  port 1 read data qualifier
s2_address, s2_chipselect, s2_read, s2_write, s2_byteenable, s2_writedata  in  as for s1  port 2 request
s2_readdata  out  DATA_W  port 2 read data
s2_readdatavalid  out  1  port 2 read data qualifier
s2_waitrequest  out  1  port 2 stall, high while clearing
clear_start  in  1  single-cycle pulse: start fill
clear_busy  out  1  fill in progress
clear_done  out  1  one-cycle pulse when fill completes

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, clear address 0, readdatavalid pipelines flushed.
- Memory contents are never reset.
- Accepted read: chipselect & read (& !waitrequest on s2). readdata and readdatavalid appear exactly READ_LATENCY cycles later.
- readdata is held between valid pulses. One read per port per cycle, fully pipelined.
- Accepted write: chipselect & write. Only lanes with byteenable=1 are updated, in the same cycle.
- Address >= DEPTH: writes are dropped; reads return 0 with readdatavalid asserted.
- read and write asserted together on one port: the write is performed; the read returns the pre-write word.
- Both ports write the same address in the same cycle: s1 wins on every overlapping lane. Non-overlapping lanes from s2 are still written.
- Cross-port read of an address written in the same cycle: behaviour depends on the optional feature (below).
- Clear FSM, IDLE -> CLEAR:
  - IDLE to CLEAR on clear_start.
  - In CLEAR, the engine owns port 2, writing FILL_VALUE (all lanes) to address 0,1,...,DEPTH-1, one word per cycle.
  - clear_busy=1 and s2_waitrequest=1 throughout CLEAR.
  - After the write to DEPTH-1, return to IDLE with clear_done=1 for that one cycle. Total duration is DEPTH cycles.
- clear_start in CLEAR is ignored (no restart).
- s1 stays fully usable during CLEAR. s1 writes colliding with engine writes win per the rule above.
- s2 reads accepted before CLEAR began still complete with readdatavalid.
- Reset mid-clear: FSM returns to IDLE, no clear_done is issued, and partially filled memory is left as is.

Optional Feature:
CHAR_BUF_SRAM_FWD_EN
- Defined: a read on either port to an address written in the same cycle by the other port, or by the clear engine, returns the new data per written lane and old data on other lanes.
- Not defined: such reads return the old word.
- Same-port read-during-write returns old data in both builds.

Decomposition:
- Package char_buf_sram_pkg holds:
  - clear_state_e enum (IDLE, CLEAR)
  - localparam BE_W = DATA_W/BYTE_W
  - a function for byte-lane merge, used by the writes and by forwarding
- Sub-module char_buf_sram_rdpipe: a READ_LATENCY-deep data/valid shift pipeline, instantiated once per port.
- Memory array and clear FSM stay in the top level.

Test Plan:
- Write 32'hDEADBEEF, be=4'hF to address 5 on s1, then s2 reads address 5 -> s2_readdata=DEADBEEF with readdatavalid exactly READ_LATENCY cycles after the read; run with READ_LATENCY=1 and 2.
- Address 7 holds 32'h11223344; s1 writes be=4'b0101, data 32'hAABBCCDD -> read returns 32'h11BB33DD.
- Same cycle, s1 writes 32'h1 and s2 writes 32'h2 to address 9 with all lanes -> address 9 reads 32'h1.
- Same cycle, s1 writes 32'h5 to address 3 while s2 reads address 3 (old value 0) -> s2 gets 32'h5 with FWD_EN defined, 32'h0 without.
- Pulse clear_start with DEPTH=2048 -> clear_busy high for 2048 cycles, s2_waitrequest high throughout, a single clear_done pulse, and addresses 0 and 2047 read 32'h00000020. A second clear_start mid-fill causes no restart.
- Assert reset at clear cycle 100 -> clear_busy drops the next cycle, no clear_done, address 50 reads 32'h20 and address 500 keeps its prior value.
